// File: rtl/periph_arb_pkg.sv
// Shared types and helpers for the peripheral round-robin arbiter.
// The search function is sized for up to MAX_MASTER requesters.
package periph_arb_pkg;

  localparam int unsigned NB_MASTER_DFLT = 4;
  localparam int unsigned ID_W           = $clog2(NB_MASTER_DFLT);
  localparam int unsigned MAX_MASTER     = 32;
  localparam int unsigned PTR_W          = 5;

  typedef logic [ID_W-1:0] id_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  // Returns {found, index} of the first set bit at or above ptr, modulo n.
  function automatic logic [PTR_W:0] rr_pick(input logic [MAX_MASTER-1:0] req,
                                             input logic [PTR_W:0]        n,
                                             input logic [PTR_W-1:0]      ptr);
    logic [PTR_W:0] idx;
    rr_pick = '0;
    for (int i = MAX_MASTER - 1; i >= 0; i--) begin
      idx = {1'b0, ptr} + (PTR_W + 1)'(i);
      if (idx >= n) idx = idx - n;
      if (((PTR_W + 1)'(i) < n) && req[idx[PTR_W-1:0]]) rr_pick = {1'b1, idx[PTR_W-1:0]};
    end
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// Small synchronous FIFO used as the in-order ID queue.
// A pop on an empty queue is ignored; a simultaneous push still lands.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  localparam int unsigned ADDR_DEPTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_DEPTH-1:0] rd_ptr_q, wr_ptr_q;
  logic [ADDR_DEPTH:0]   cnt_q;
  logic                  do_push, do_pop, bypass;

  assign full_o  = (cnt_q == (ADDR_DEPTH + 1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign bypass  = FALL_THROUGH && empty_o && push_i && pop_i;
  assign do_push = push_i && !full_o && !bypass;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = (FALL_THROUGH && empty_o) ? data_i : mem[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/periph_rr_arbiter.sv
// Round-robin arbiter sharing one peripheral port; responses routed back in order.
// state  | meaning
// IDLE   | winner chosen by round-robin search from rr_ptr
// LOCKED | request stalled downstream; winner held at lock_id
module periph_rr_arbiter
  import periph_arb_pkg::*;
#(
  parameter int unsigned NB_MASTER       = 4,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NB_MASTER-1:0]                  m_req_i,
  input  logic [NB_MASTER-1:0][ADDR_WIDTH-1:0]  m_add_i,
  input  logic [NB_MASTER-1:0]                  m_we_n_i,
  input  logic [NB_MASTER-1:0][DATA_WIDTH-1:0]  m_wdata_i,
  input  logic [NB_MASTER-1:0][BE_WIDTH-1:0]    m_be_i,
  output logic [NB_MASTER-1:0]                  m_gnt_o,
  output logic [NB_MASTER-1:0]                  m_r_valid_o,
  output logic                                  m_r_opc_o,
  output logic [DATA_WIDTH-1:0]                 m_r_rdata_o,
  output logic                                  s_req_o,
  output logic [ADDR_WIDTH-1:0]                 s_add_o,
  output logic                                  s_we_n_o,
  output logic [DATA_WIDTH-1:0]                 s_wdata_o,
  output logic [BE_WIDTH-1:0]                   s_be_o,
  input  logic                                  s_gnt_i,
  input  logic                                  s_r_valid_i,
  input  logic                                  s_r_opc_i,
  input  logic [DATA_WIDTH-1:0]                 s_r_rdata_i,
  output logic                                  err_o
);

  localparam int unsigned IW = (NB_MASTER > 1) ? $clog2(NB_MASTER) : 1;

  lock_state_e     state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, lock_id_q, lock_id_d, win, head;
  logic [PTR_W:0]  pick;
  logic            id_full, id_empty, hs, pop;
  logic            r_valid_q, r_opc_q, err_q;
  logic [IW-1:0]   r_id_q;
  logic [DATA_WIDTH-1:0] r_rdata_q;

  always_comb begin
    pick = rr_pick(MAX_MASTER'(m_req_i), (PTR_W + 1)'(NB_MASTER), PTR_W'(rr_ptr_q));
    win  = '0;
    if (state_q == LOCKED) win = lock_id_q;
    else if (pick[PTR_W])  win = IW'(pick[PTR_W-1:0]);
  end

  // No lookahead on a same-cycle pop: a full queue always blocks the request.
  assign s_req_o   = (|m_req_i) && !id_full;
  assign hs        = s_req_o && s_gnt_i;
  assign s_add_o   = m_add_i[win];
  assign s_we_n_o  = m_we_n_i[win];
  assign s_wdata_o = m_wdata_i[win];
  assign s_be_o    = m_be_i[win];

  always_comb begin
    m_gnt_o = '0;
    if (hs) m_gnt_o[win] = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    case (state_q)
      IDLE: begin
        if (s_req_o && !s_gnt_i) begin
          state_d   = LOCKED;
          lock_id_d = win;
        end
      end
      LOCKED: begin
        if (hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      lock_id_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      if (hs) rr_ptr_q <= (win == IW'(NB_MASTER - 1)) ? '0 : win + 1'b1;
    end
  end

  assign pop = s_r_valid_i && !id_empty;

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   (IW),
    .DEPTH        (MAX_OUTSTANDING)
  ) i_id_queue (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .full_o  (id_full),
    .empty_o (id_empty),
    .data_i  (win),
    .push_i  (hs),
    .data_o  (head),
    .pop_i   (pop)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid_q <= 1'b0;
      r_id_q    <= '0;
      r_opc_q   <= 1'b0;
      r_rdata_q <= '0;
      err_q     <= 1'b0;
    end else begin
      r_valid_q <= pop;
      if (pop) begin
        r_id_q    <= head;
        r_opc_q   <= s_r_opc_i;
        r_rdata_q <= s_r_rdata_i;
      end
      if (s_r_valid_i && id_empty) err_q <= 1'b1;
    end
  end

  always_comb begin
    m_r_valid_o = '0;
    if (r_valid_q) m_r_valid_o[r_id_q] = 1'b1;
  end

  assign m_r_opc_o   = r_opc_q;
  assign m_r_rdata_o = r_rdata_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_periph_rr_arbiter.sv
// Directed bench for periph_rr_arbiter with hand-computed expectations.
module tb_periph_rr_arbiter;

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic [3:0]            m_req_i;
  logic [3:0][31:0]      m_add_i;
  logic [3:0]            m_we_n_i;
  logic [3:0][31:0]      m_wdata_i;
  logic [3:0][3:0]       m_be_i;
  logic [3:0]            m_gnt_o;
  logic [3:0]            m_r_valid_o;
  logic                  m_r_opc_o;
  logic [31:0]           m_r_rdata_o;
  logic                  s_req_o;
  logic [31:0]           s_add_o;
  logic                  s_we_n_o;
  logic [31:0]           s_wdata_o;
  logic [3:0]            s_be_o;
  logic                  s_gnt_i;
  logic                  s_r_valid_i;
  logic                  s_r_opc_i;
  logic [31:0]           s_r_rdata_i;
  logic                  err_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  periph_rr_arbiter #(
    .NB_MASTER(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .BE_WIDTH(4), .MAX_OUTSTANDING(4)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m_req_i(m_req_i), .m_add_i(m_add_i), .m_we_n_i(m_we_n_i),
    .m_wdata_i(m_wdata_i), .m_be_i(m_be_i),
    .m_gnt_o(m_gnt_o), .m_r_valid_o(m_r_valid_o), .m_r_opc_o(m_r_opc_o),
    .m_r_rdata_o(m_r_rdata_o),
    .s_req_o(s_req_o), .s_add_o(s_add_o), .s_we_n_o(s_we_n_o),
    .s_wdata_o(s_wdata_o), .s_be_o(s_be_o),
    .s_gnt_i(s_gnt_i), .s_r_valid_i(s_r_valid_i), .s_r_opc_i(s_r_opc_i),
    .s_r_rdata_i(s_r_rdata_i), .err_o(err_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; checks follow 1 ns later.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [31:0] addr_of(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h100;
  endfunction

  initial begin
    rst_ni      = 1'b0;
    m_req_i     = '0;
    m_we_n_i    = 4'b0101;
    s_gnt_i     = 1'b0;
    s_r_valid_i = 1'b0;
    s_r_opc_i   = 1'b0;
    s_r_rdata_i = '0;
    for (int i = 0; i < 4; i++) begin
      m_add_i[i]   = addr_of(i);
      m_wdata_i[i] = 32'hD000_0000 + 32'(i);
    end
    m_be_i[0] = 4'h1; m_be_i[1] = 4'h3; m_be_i[2] = 4'hC; m_be_i[3] = 4'hF;

    // Reset values
    #2;
    chk("rst_r_valid", m_r_valid_o, 4'b0000);
    chk("rst_rdata",   m_r_rdata_o, 32'h0);
    chk("rst_opc",     m_r_opc_o,   1'b0);
    chk("rst_err",     err_o,       1'b0);
    chk("rst_s_req",   s_req_o,     1'b0);
    chk("rst_gnt",     m_gnt_o,     4'b0000);
    #10 rst_ni = 1'b1;

    // A: all four request, grants rotate, responses two cycles after each handshake
    cyc(); m_req_i = 4'b1111; s_gnt_i = 1'b1; settle();
    chk("a_gnt0", m_gnt_o, 4'b0001);
    chk("a_add0", s_add_o, addr_of(0));
    chk("a_we0",  s_we_n_o, 1'b1);
    cyc(); settle();
    chk("a_gnt1",   m_gnt_o, 4'b0010);
    chk("a_wdata1", s_wdata_o, 32'hD000_0001);
    chk("a_we1",    s_we_n_o, 1'b0);
    cyc(); s_r_valid_i = 1'b1; s_r_rdata_i = 32'h11; settle();
    chk("a_gnt2", m_gnt_o, 4'b0100);
    chk("a_be2",  s_be_o, 4'hC);
    cyc(); s_r_rdata_i = 32'h22; settle();
    chk("a_gnt3",  m_gnt_o, 4'b1000);
    chk("a_rv0",   m_r_valid_o, 4'b0001);
    chk("a_rd0",   m_r_rdata_o, 32'h11);
    cyc(); s_r_rdata_i = 32'h33; settle();
    chk("a_gnt0b", m_gnt_o, 4'b0001);
    chk("a_rv1",   m_r_valid_o, 4'b0010);
    chk("a_rd1",   m_r_rdata_o, 32'h22);
    cyc(); m_req_i = 4'b0000; s_r_rdata_i = 32'h44; settle();
    chk("a_sreq_idle", s_req_o, 1'b0);
    chk("a_rv2", m_r_valid_o, 4'b0100);
    cyc(); s_r_rdata_i = 32'h55; settle();
    chk("a_rv3", m_r_valid_o, 4'b1000);
    cyc(); s_r_valid_i = 1'b0; settle();
    chk("a_rv0b", m_r_valid_o, 4'b0001);
    chk("a_rd0b", m_r_rdata_o, 32'h55);
    cyc(); settle();
    chk("a_rv_none", m_r_valid_o, 4'b0000);

    // B: requester 2 stalls downstream, requester 1 arrives; rr_ptr is 1 here
    m_req_i = 4'b0100; s_gnt_i = 1'b0; settle();
    chk("b_sreq", s_req_o, 1'b1);
    chk("b_gnt_stall", m_gnt_o, 4'b0000);
    cyc(); m_req_i = 4'b0110; settle();
    chk("b_add_lock1", s_add_o, addr_of(2));
    cyc(); settle();
    chk("b_add_lock2", s_add_o, addr_of(2));
    cyc(); s_gnt_i = 1'b1; settle();
    chk("b_gnt2", m_gnt_o, 4'b0100);
    chk("b_add3", s_add_o, addr_of(2));
    cyc(); m_req_i = 4'b0010; settle();
    chk("b_gnt1", m_gnt_o, 4'b0010);
    cyc(); m_req_i = 4'b0000; s_r_valid_i = 1'b1; s_r_rdata_i = 32'h5; settle();
    cyc(); settle();
    chk("b_rv2", m_r_valid_o, 4'b0100);
    cyc(); s_r_valid_i = 1'b0; settle();
    chk("b_rv1", m_r_valid_o, 4'b0010);

    // C: fill the ID queue (rr_ptr = 2), then one response frees one slot
    cyc(); m_req_i = 4'b1111; settle();
    chk("c_gnt2", m_gnt_o, 4'b0100);
    cyc(); settle();
    chk("c_gnt3", m_gnt_o, 4'b1000);
    cyc(); settle();
    chk("c_gnt0", m_gnt_o, 4'b0001);
    cyc(); settle();
    chk("c_gnt1", m_gnt_o, 4'b0010);
    cyc(); s_r_valid_i = 1'b1; s_r_rdata_i = 32'h60; settle();
    chk("c_full_sreq", s_req_o, 1'b0);
    chk("c_full_gnt",  m_gnt_o, 4'b0000);
    cyc(); s_r_valid_i = 1'b0; settle();
    chk("c_free_sreq", s_req_o, 1'b1);
    chk("c_free_gnt",  m_gnt_o, 4'b0100);
    chk("c_rv2",       m_r_valid_o, 4'b0100);
    cyc(); m_req_i = 4'b0000; s_r_valid_i = 1'b1; s_r_rdata_i = 32'h61; settle();
    cyc(); s_r_rdata_i = 32'h62; settle();
    chk("c_rv3", m_r_valid_o, 4'b1000);
    cyc(); s_r_rdata_i = 32'h63; settle();
    chk("c_rv0", m_r_valid_o, 4'b0001);
    chk("c_rd0", m_r_rdata_o, 32'h62);
    cyc(); s_r_rdata_i = 32'h64; settle();
    chk("c_rv1", m_r_valid_o, 4'b0010);
    cyc(); s_r_valid_i = 1'b0; settle();
    chk("c_rv2b", m_r_valid_o, 4'b0100);
    chk("c_rd2b", m_r_rdata_o, 32'h64);

    // D: interleaved reads 3, 0, 3 (rr_ptr = 3)
    m_we_n_i = 4'b1111;
    cyc(); m_req_i = 4'b1000; settle();
    chk("d_gnt3a", m_gnt_o, 4'b1000);
    chk("d_we",    s_we_n_o, 1'b1);
    cyc(); m_req_i = 4'b0001; settle();
    chk("d_gnt0", m_gnt_o, 4'b0001);
    cyc(); m_req_i = 4'b1000; settle();
    chk("d_gnt3b", m_gnt_o, 4'b1000);
    cyc(); m_req_i = 4'b0000; s_r_valid_i = 1'b1; s_r_rdata_i = 32'hA; s_r_opc_i = 1'b0; settle();
    cyc(); s_r_rdata_i = 32'hB; s_r_opc_i = 1'b1; settle();
    chk("d_rv_a", m_r_valid_o, 4'b1000);
    chk("d_rd_a", m_r_rdata_o, 32'hA);
    chk("d_op_a", m_r_opc_o, 1'b0);
    cyc(); s_r_rdata_i = 32'hC; s_r_opc_i = 1'b0; settle();
    chk("d_rv_b", m_r_valid_o, 4'b0001);
    chk("d_rd_b", m_r_rdata_o, 32'hB);
    chk("d_op_b", m_r_opc_o, 1'b1);
    cyc(); s_r_valid_i = 1'b0; settle();
    chk("d_rv_c", m_r_valid_o, 4'b1000);
    chk("d_rd_c", m_r_rdata_o, 32'hC);
    chk("d_err_clean", err_o, 1'b0);

    // E: response with nothing outstanding
    cyc(); s_r_valid_i = 1'b1; s_r_rdata_i = 32'hDEAD; settle();
    cyc(); s_r_valid_i = 1'b0; settle();
    chk("e_no_rv", m_r_valid_o, 4'b0000);
    chk("e_err",   err_o, 1'b1);
    cyc(); cyc(); settle();
    chk("e_err_sticky", err_o, 1'b1);

    // F: reset with two outstanding (rr_ptr = 0)
    cyc(); m_req_i = 4'b0011; settle();
    chk("f_gnt0", m_gnt_o, 4'b0001);
    cyc(); settle();
    chk("f_gnt1", m_gnt_o, 4'b0010);
    cyc(); m_req_i = 4'b0000; settle();
    rst_ni = 1'b0; settle();
    chk("f_rst_err",   err_o, 1'b0);
    chk("f_rst_rv",    m_r_valid_o, 4'b0000);
    chk("f_rst_rdata", m_r_rdata_o, 32'h0);
    chk("f_rst_sreq",  s_req_o, 1'b0);
    rst_ni = 1'b1;
    cyc(); s_r_valid_i = 1'b1; s_r_rdata_i = 32'h77; settle();
    cyc(); s_r_valid_i = 1'b0; settle();
    chk("f_post_rv",  m_r_valid_o, 4'b0000);
    chk("f_post_err", err_o, 1'b1);
    cyc(); m_req_i = 4'b0110; s_gnt_i = 1'b1; settle();
    chk("f_ptr_rst_gnt", m_gnt_o, 4'b0010);
    chk("f_ptr_rst_add", s_add_o, addr_of(1));
    cyc(); m_req_i = 4'b0000; s_gnt_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/periph_rr_arbiter.md
# periph_rr_arbiter

Round-robin arbiter that shares one peripheral request port among `NB_MASTER` requesters and routes each response back to the requester that issued it. It sits in front of the cluster's peripheral request FIFO, whose input handshake it drives. A small in-order ID queue tracks outstanding transactions, and a lock register keeps the selected requester stable while the downstream port stalls.

## Interface
- `NB_MASTER`, 4: number of requesters; must be at least 2.
- `ADDR_WIDTH`, 32: address width.
- `DATA_WIDTH`, 32: data width.
- `BE_WIDTH`, `DATA_WIDTH/8`: byte-enable width.
- `MAX_OUTSTANDING`, 4: ID queue depth; must be a power of two, at least 2.
- `clk_i` in 1: the single clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `m_req_i` in `NB_MASTER`: per-requester request.
- `m_add_i` in `NB_MASTER`x`ADDR_WIDTH`: per-requester address.
- `m_we_n_i` in `NB_MASTER`: per-requester write enable, active low (0 = write).
- `m_wdata_i` in `NB_MASTER`x`DATA_WIDTH`: per-requester write data.
- `m_be_i` in `NB_MASTER`x`BE_WIDTH`: per-requester byte enables.
- `m_gnt_o` out `NB_MASTER`: per-requester grant (one-hot or zero).
- `m_r_valid_o` out `NB_MASTER`: per-requester response valid (one-hot or zero).
- `m_r_opc_o` out 1: response opcode/error bit, broadcast to all requesters.
- `m_r_rdata_o` out `DATA_WIDTH`: response read data, broadcast to all requesters.
- `s_req_o` out 1: downstream request.
- `s_add_o` out `ADDR_WIDTH`: downstream address.
- `s_we_n_o` out 1: downstream write enable, active low.
- `s_wdata_o` out `DATA_WIDTH`: downstream write data.
- `s_be_o` out `BE_WIDTH`: downstream byte enables.
- `s_gnt_i` in 1: downstream grant.
- `s_r_valid_i` in 1: downstream response valid.
- `s_r_opc_i` in 1: downstream response opcode/error bit.
- `s_r_rdata_i` in `DATA_WIDTH`: downstream response read data.
- `err_o` out 1: sticky flag; set by a response that arrives with no outstanding request.

## Operation
**Protocol**
- Every accepted request, read or write, returns exactly one `s_r_valid_i` pulse.
- Responses return in acceptance order.
- A requester holds its request and payload stable until it is granted.

**Arbitration**
- Winner = first `m_req_i` bit set, searching from `rr_ptr` upward modulo `NB_MASTER`.
- `s_req_o` = (any `m_req_i`) AND NOT `id_full`.
- `s_add_o`, `s_we_n_o`, `s_wdata_o` and `s_be_o` are driven from the winner's inputs.
- `m_gnt_o[w]` = `s_gnt_i` AND `s_req_o`, for the winner `w` only.
- Handshake = `s_req_o` AND `s_gnt_i`. On a handshake:
  - `rr_ptr` <= (w+1) mod `NB_MASTER`;
  - w is pushed into the ID queue.

**Lock FSM**
- States: IDLE, LOCKED.
- IDLE -> LOCKED when `s_req_o` is high and `s_gnt_i` is low; `lock_id` <= w.
- In LOCKED the winner is forced to `lock_id`, whatever the other requests or `rr_ptr` are.
- LOCKED -> IDLE on the handshake.

**Responses**
- On `s_r_valid_i`, pop the ID queue head h.
- Next cycle: `m_r_valid_o[h]` = 1, and `m_r_opc_o` / `m_r_rdata_o` carry the registered `s_r_opc_i` / `s_r_rdata_i`.
- `s_r_valid_i` with the ID queue empty: the response is dropped, no `m_r_valid_o` pulse is produced, and `err_o` <= 1.

**Boundaries**
- ID queue full: `s_req_o` = 0, even if a pop happens in the same cycle. No lookahead.
- Push and pop in the same cycle with the queue non-empty: both take effect; occupancy is unchanged.
- A push and a pop into an empty queue in the same cycle count as an empty-pop error. The pushed ID is kept.
- `rr_ptr` wraps from `NB_MASTER`-1 to 0.
- Reset asserted mid-transaction discards all outstanding IDs. Responses that arrive after reset set `err_o`.

## Timing
- Request path is combinational from requester inputs to `s_*`, and from `s_gnt_i` to `m_gnt_o`.
- Response latency: exactly 1 cycle from `s_r_valid_i` to `m_r_valid_o`.
- Back-to-back handshakes are allowed every cycle, up to `MAX_OUTSTANDING` in flight.
- Reset values:
  - `rr_ptr` = 0, state = IDLE, `lock_id` = 0, ID queue empty;
  - `m_r_valid_o` = 0, `m_r_opc_o` = 0, `m_r_rdata_o` = 0, `err_o` = 0;
  - combinational outputs `s_req_o` and `m_gnt_o` are 0 whenever no request is present.

## Structure
- Package `periph_arb_pkg`:
  - `ID_W` = $clog2(`NB_MASTER`) and the ID typedef;
  - the lock FSM state enum;
  - a round-robin priority search function.
- Sub-module: the ID queue is a `fifo_v3` instance with `FALL_THROUGH`=0, `DEPTH`=`MAX_OUTSTANDING`, `DATA_WIDTH`=`ID_W`. `full_o` provides `id_full`.
- The arbiter, lock FSM and response register live in the top module.

## Test plan
- Requesters 0–3 request continuously, `s_gnt_i`=1, responses 2 cycles after each handshake -> grants go 0,1,2,3,0; each `m_r_valid_o` lands on the issuing requester 1 cycle after its `s_r_valid_i`.
- Requester 2 requests with `s_gnt_i`=0 for 3 cycles while requester 1 raises its request -> `s_add_o` stays requester 2's address; requester 2 is granted first, then requester 1.
- 4 handshakes with no responses (`MAX_OUTSTANDING`=4) -> `s_req_o`=0 and all `m_gnt_o`=0; after one response, `s_req_o`=1 the following cycle.
- Interleaved reads from requesters 3, 0, 3 returning rdata 0xA, 0xB, 0xC -> requester 3 sees 0xA, requester 0 sees 0xB, requester 3 sees 0xC, in that order.
- `s_r_valid_i`=1 with nothing outstanding -> no `m_r_valid_o` pulse; `err_o`=1 and it stays 1 until reset.
- Reset asserted with 2 outstanding requests -> all outputs return to reset values; the next response sets `err_o`.
